// File: rtl/rv32i_types.sv
// Shared types and helpers for the commit stage: FSM states, the per-cycle
// head decision, and small pure functions used by the commit controller.
package rv32i_types;

    localparam int XLEN             = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int ROB_DEPTH_DFLT   = 32;
    localparam int ROB_IDX_W        = $clog2(ROB_DEPTH_DFLT);
    localparam int COMMIT_CNT_W     = 64;

    // Commit FSM states; explicit encodings keep waveforms stable across builds.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        RECOVER    = 2'd2
    } commit_state_t;

    // What the head entry asks for in a RUN cycle.
    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_COMMIT = 2'd1,
        ACT_STORE  = 2'd2,
        ACT_FLUSH  = 2'd3
    } commit_action_t;

    // A control-flow instruction whose resolved direction disagrees with
    // the prediction made at fetch.
    function automatic logic is_mispredict(
        input logic is_ctrl,
        input logic br_en,
        input logic prediction
    );
        return is_ctrl && (br_en != prediction);
    endfunction

    // Correct fetch target after a mispredict: the resolved target when the
    // branch was taken, otherwise the fall-through instruction.
    function automatic logic [XLEN-1:0] redirect_target(
        input logic            br_en,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] pc_new
    );
        return br_en ? pc_new : (pc + XLEN'(4));
    endfunction

    // x0 is hardwired to zero, so a write to it is dropped.
    function automatic logic rd_writable(
        input logic                  regf_we,
        input logic [REG_ADDR_W-1:0] rd_addr
    );
        return regf_we && (rd_addr != '0);
    endfunction

endpackage

// File: rtl/flush_timer.sv
// Loadable down-counter that times the post-flush recovery window.
// done is high while the count is at its final cycle (1) or has run out,
// so the owner can leave the recovery state on that cycle.
module flush_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Load has priority over decrement; the counter never underflows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    // Treat an empty counter as done too so the owner can never get stuck.
    always_comb begin
        done = (count_reg <= W'(1));
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order retirement controller at the reorder buffer head. Each RUN cycle
// it commits the head, releases a store to the LSQ, or raises a flush and
// fetch redirect on a mispredict. It owns the ROB pop strobe, the global
// flush, the dispatch stall and the retired-instruction counter.
module rob_commit_ctrl
    import rv32i_types::*;
#(
    parameter int ROB_DEPTH    = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          head_valid,
    input  logic                          head_done,
    input  logic [$clog2(ROB_DEPTH)-1:0]  head_rob_idx,
    input  logic [XLEN-1:0]               head_pc,
    input  logic [REG_ADDR_W-1:0]         head_rd_addr,
    input  logic [XLEN-1:0]               head_rd_data,
    input  logic                          head_regf_we,
    input  logic                          head_is_store,
    input  logic                          head_is_ctrl,
    input  logic                          head_br_en,
    input  logic                          head_prediction,
    input  logic [XLEN-1:0]               head_pc_new,
    input  logic                          store_ack,
    output logic                          dequeue_o,
    output logic                          regf_we_o,
    output logic [REG_ADDR_W-1:0]         regf_rd_addr_o,
    output logic [XLEN-1:0]               regf_rd_data_o,
    output logic [$clog2(ROB_DEPTH)-1:0]  regf_rob_idx_o,
    output logic                          store_commit_req_o,
    output logic                          flush_o,
    output logic                          redirect_valid_o,
    output logic [XLEN-1:0]               redirect_pc_o,
    output logic                          dispatch_stall_o,
    output logic [COMMIT_CNT_W-1:0]       commit_count_o
);

    // A zero-length recovery window is not meaningful; clamp to one cycle.
    localparam int FLUSH_LOAD = (FLUSH_CYCLES < 1) ? 1 : FLUSH_CYCLES;
    localparam int TIMER_W    = $clog2(FLUSH_LOAD + 1);

    commit_state_t              state_reg;
    commit_state_t              state_next;
    logic                       ack_seen_reg;
    logic                       ack_seen_next;
    logic [COMMIT_CNT_W-1:0]    commit_count_reg;

    commit_action_t             action;
    logic                       rd_write;
    logic                       store_done;
    logic                       timer_load;
    logic                       timer_dec;
    logic                       timer_done;

    flush_timer #(
        .W (TIMER_W)
    ) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TIMER_W'(FLUSH_LOAD)),
        .dec      (timer_dec),
        .done     (timer_done)
    );

    // Classify the head entry; stores win over control flow.
    always_comb begin
        action = ACT_NONE;
        if (head_valid && head_done) begin
            if (head_is_store) begin
                action = ACT_STORE;
            end else if (is_mispredict(head_is_ctrl, head_br_en, head_prediction)) begin
                action = ACT_FLUSH;
            end else begin
                action = ACT_COMMIT;
            end
        end
        rd_write = rd_writable(head_regf_we, head_rd_addr);
        // An ack coincident with the first request cycle is remembered so
        // the store still retires on the following STORE_WAIT cycle.
        store_done = store_ack || ack_seen_reg;
    end

    // Strobes and next state. Everything is held at zero while in reset.
    always_comb begin
        state_next         = state_reg;
        ack_seen_next      = 1'b0;
        timer_load         = 1'b0;
        timer_dec          = 1'b0;
        dequeue_o          = 1'b0;
        regf_we_o          = 1'b0;
        store_commit_req_o = 1'b0;
        flush_o            = 1'b0;
        redirect_valid_o   = 1'b0;
        redirect_pc_o      = '0;
        dispatch_stall_o   = 1'b0;

        case (state_reg)
            RUN: begin
                case (action)
                    ACT_STORE: begin
                        store_commit_req_o = 1'b1;
                        ack_seen_next      = store_ack;
                        state_next         = STORE_WAIT;
                    end
                    ACT_FLUSH: begin
                        dequeue_o        = 1'b1;
                        regf_we_o        = rd_write;
                        flush_o          = 1'b1;
                        redirect_valid_o = 1'b1;
                        redirect_pc_o    = redirect_target(head_br_en, head_pc, head_pc_new);
                        dispatch_stall_o = 1'b1;
                        timer_load       = 1'b1;
                        state_next       = RECOVER;
                    end
                    ACT_COMMIT: begin
                        dequeue_o = 1'b1;
                        regf_we_o = rd_write;
                    end
                    default: begin
                    end
                endcase
            end
            STORE_WAIT: begin
                if (store_done) begin
                    dequeue_o  = 1'b1;
                    state_next = RUN;
                end else begin
                    store_commit_req_o = 1'b1;
                end
            end
            RECOVER: begin
                dispatch_stall_o = 1'b1;
                timer_dec        = 1'b1;
                if (timer_done) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (!rst) begin
            state_next         = RUN;
            ack_seen_next      = 1'b0;
            timer_load         = 1'b0;
            timer_dec          = 1'b0;
            dequeue_o          = 1'b0;
            regf_we_o          = 1'b0;
            store_commit_req_o = 1'b0;
            flush_o            = 1'b0;
            redirect_valid_o   = 1'b0;
            redirect_pc_o      = '0;
            dispatch_stall_o   = 1'b0;
        end
    end

    // Architectural write port mirrors the head only when actually writing.
    always_comb begin
        regf_rd_addr_o = regf_we_o ? head_rd_addr : '0;
        regf_rd_data_o = regf_we_o ? head_rd_data : '0;
        regf_rob_idx_o = regf_we_o ? head_rob_idx : '0;
    end

    // FSM state and the remembered early store acknowledge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= RUN;
            ack_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ack_seen_reg <= ack_seen_next;
        end
    end

    // Retired-instruction counter, free-running modulo 2^64.
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_count_reg <= '0;
        end else if (dequeue_o) begin
            commit_count_reg <= commit_count_reg + COMMIT_CNT_W'(1);
        end
    end

    assign commit_count_o = commit_count_reg;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Randomized scoreboard bench for rob_commit_ctrl. A driver acts as the ROB
// and LSQ, pushing the expected retirement record of every head it presents;
// a negedge monitor checks cycle behaviour and pops records on each dequeue.
module tb_rob_commit_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int N_RANDOM     = 200;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        is_store;
        logic        is_ctrl;
        logic        br_en;
        logic        pred;
        logic [31:0] pc_new;
    } instr_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  idx;
        logic        mispredict;
        logic [31:0] rpc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        head_valid = 1'b0;
    logic        head_done = 1'b0;
    logic [4:0]  head_rob_idx = '0;
    logic [31:0] head_pc = '0;
    logic [4:0]  head_rd_addr = '0;
    logic [31:0] head_rd_data = '0;
    logic        head_regf_we = 1'b0;
    logic        head_is_store = 1'b0;
    logic        head_is_ctrl = 1'b0;
    logic        head_br_en = 1'b0;
    logic        head_prediction = 1'b0;
    logic [31:0] head_pc_new = '0;
    logic        store_ack = 1'b0;

    logic        dequeue_o;
    logic        regf_we_o;
    logic [4:0]  regf_rd_addr_o;
    logic [31:0] regf_rd_data_o;
    logic [4:0]  regf_rob_idx_o;
    logic        store_commit_req_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        dispatch_stall_o;
    logic [63:0] commit_count_o;

    int          tests = 0;
    int          fails = 0;
    logic        mon_en = 1'b0;
    logic        abort = 1'b0;
    rec_t        exp_q[$];
    longint      model_count = 0;
    int          stall_left = 0;
    logic        deq_seen = 1'b0;
    logic        req_seen = 1'b0;
    logic [4:0]  next_idx = '0;

    rob_commit_ctrl #(
        .ROB_DEPTH    (32),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .head_valid         (head_valid),
        .head_done          (head_done),
        .head_rob_idx       (head_rob_idx),
        .head_pc            (head_pc),
        .head_rd_addr       (head_rd_addr),
        .head_rd_data       (head_rd_data),
        .head_regf_we       (head_regf_we),
        .head_is_store      (head_is_store),
        .head_is_ctrl       (head_is_ctrl),
        .head_br_en         (head_br_en),
        .head_prediction    (head_prediction),
        .head_pc_new        (head_pc_new),
        .store_ack          (store_ack),
        .dequeue_o          (dequeue_o),
        .regf_we_o          (regf_we_o),
        .regf_rd_addr_o     (regf_rd_addr_o),
        .regf_rd_data_o     (regf_rd_data_o),
        .regf_rob_idx_o     (regf_rob_idx_o),
        .store_commit_req_o (store_commit_req_o),
        .flush_o            (flush_o),
        .redirect_valid_o   (redirect_valid_o),
        .redirect_pc_o      (redirect_pc_o),
        .dispatch_stall_o   (dispatch_stall_o),
        .commit_count_o     (commit_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected retirement of one instruction, straight from the commit rules.
    function automatic rec_t model(input instr_t in, input logic [4:0] idx);
        rec_t r;
        r.mispredict = !in.is_store && in.is_ctrl && (in.br_en != in.pred);
        r.we         = !in.is_store && in.we && (in.rd != 5'd0);
        r.rd         = in.rd;
        r.data       = in.data;
        r.idx        = idx;
        r.rpc        = in.br_en ? in.pc_new : in.pc + 32'd4;
        return r;
    endfunction

    // Monitor: per-cycle expectations plus scoreboard pop on every dequeue.
    logic mon_exp_deq, mon_exp_req, mon_flush_now, mon_exp_stall;
    rec_t mon_r;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp_deq = head_valid && head_done &&
                          (head_is_store ? store_ack : (stall_left == 0));
            mon_exp_req = head_valid && head_done && head_is_store &&
                          (stall_left == 0) && !store_ack;
            mon_flush_now = mon_exp_deq && (exp_q.size() > 0) && exp_q[0].mispredict;
            mon_exp_stall = (stall_left > 0) || mon_flush_now;
            chk("dequeue", {63'd0, dequeue_o}, {63'd0, mon_exp_deq});
            chk("store_req", {63'd0, store_commit_req_o}, {63'd0, mon_exp_req});
            chk("dispatch_stall", {63'd0, dispatch_stall_o}, {63'd0, mon_exp_stall});
            chk("commit_count", commit_count_o, model_count);
            if (dequeue_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_dequeue", 64'd1, 64'd0);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("regf_we", {63'd0, regf_we_o}, {63'd0, mon_r.we});
                    if (mon_r.we) begin
                        chk("regf_addr", {59'd0, regf_rd_addr_o}, {59'd0, mon_r.rd});
                        chk("regf_data", {32'd0, regf_rd_data_o}, {32'd0, mon_r.data});
                        chk("regf_idx", {59'd0, regf_rob_idx_o}, {59'd0, mon_r.idx});
                    end
                    chk("flush", {63'd0, flush_o}, {63'd0, mon_r.mispredict});
                    chk("redirect_valid", {63'd0, redirect_valid_o}, {63'd0, mon_r.mispredict});
                    if (mon_r.mispredict)
                        chk("redirect_pc", {32'd0, redirect_pc_o}, {32'd0, mon_r.rpc});
                    $display("[TB] retire idx=%0d we=%0d rd=%0d data=0x%08h flush=%0d pc=0x%08h",
                             mon_r.idx, mon_r.we, mon_r.rd, mon_r.data, mon_r.mispredict, mon_r.rpc);
                    model_count++;
                    if (mon_r.mispredict) stall_left = FLUSH_CYCLES;
                    else if (stall_left > 0) stall_left--;
                end
            end else begin
                chk("flush_idle", {63'd0, flush_o}, 64'd0);
                chk("redirect_idle", {63'd0, redirect_valid_o}, 64'd0);
                if (stall_left > 0) stall_left--;
            end
        end
    end

    // One clock: observe at the negedge, return just after the next posedge.
    task automatic tick();
        @(negedge clk);
        deq_seen = dequeue_o;
        req_seen = store_commit_req_o;
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input instr_t in, input logic [4:0] idx);
        head_rob_idx    = idx;
        head_pc         = in.pc;
        head_rd_addr    = in.rd;
        head_rd_data    = in.data;
        head_regf_we    = in.we;
        head_is_store   = in.is_store;
        head_is_ctrl    = in.is_ctrl;
        head_br_en      = in.br_en;
        head_prediction = in.pred;
        head_pc_new     = in.pc_new;
    endtask

    // Present one instruction at the head and play the ROB/LSQ until it pops.
    task automatic issue(input instr_t in);
        int ack_delay;
        int budget;
        logic popped;
        store_ack = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            head_valid = 1'b0;
            head_done  = 1'b1;
            tick();
        end
        exp_q.push_back(model(in, next_idx));
        set_head(in, next_idx);
        head_valid = 1'b1;
        head_done  = 1'b0;
        for (int i = 0; i < $urandom_range(0, 2); i++) begin
            if (!in.is_store) store_ack = ($urandom_range(0, 3) == 0);
            tick();
        end
        head_done = 1'b1;
        store_ack = 1'b0;
        ack_delay = $urandom_range(0, 3);
        popped = 1'b0;
        budget = 0;
        while (!popped && budget < 64) begin
            tick();
            if (deq_seen) begin
                popped = 1'b1;
            end else begin
                store_ack = 1'b0;
                if (in.is_store && req_seen) begin
                    if (ack_delay == 0) store_ack = 1'b1;
                    else ack_delay--;
                end else if (!in.is_store) begin
                    store_ack = ($urandom_range(0, 3) == 0);
                end
                budget++;
            end
        end
        store_ack = 1'b0;
        head_valid = 1'b0;
        if (!popped) begin
            tests++;
            fails++;
            $display("[TB] FAIL retire_timeout: idx %0d not dequeued within 64 cycles", next_idx);
            abort = 1'b1;
        end
        next_idx = next_idx + 5'd1;
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                  input logic [31:0] data, input logic we,
                                  input logic st, input logic ctrl, input logic br,
                                  input logic pr, input logic [31:0] pcn);
        instr_t t;
        t.pc = pc; t.rd = rd; t.data = data; t.we = we; t.is_store = st;
        t.is_ctrl = ctrl; t.br_en = br; t.pred = pr; t.pc_new = pcn;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        kind       = $urandom_range(0, 7);
        t.pc       = $urandom & 32'hFFFF_FFFC;
        t.pc_new   = $urandom & 32'hFFFF_FFFC;
        t.rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        t.data     = $urandom;
        t.we       = 1'($urandom_range(0, 1));
        t.is_store = (kind < 2);
        t.is_ctrl  = (kind >= 2) && (kind <= 4);
        t.br_en    = 1'($urandom_range(0, 1));
        t.pred     = 1'($urandom_range(0, 1));
        if (t.is_store) t.we = 1'b0;
        return t;
    endfunction

    initial begin
        // Reset with a committable head: everything must stay quiet.
        rst = 1'b0;
        set_head(mk(32'h40, 5'd7, 32'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80), 5'd3);
        head_valid = 1'b1;
        head_done  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dequeue", {63'd0, dequeue_o}, 64'd0);
        chk("reset_regf_we", {63'd0, regf_we_o}, 64'd0);
        chk("reset_flush", {63'd0, flush_o}, 64'd0);
        chk("reset_redirect", {63'd0, redirect_valid_o}, 64'd0);
        chk("reset_stall", {63'd0, dispatch_stall_o}, 64'd0);
        chk("reset_count", commit_count_o, 64'd0);
        @(posedge clk);
        #1;
        head_valid = 1'b0;
        rst = 1'b1;
        mon_en = 1'b1;

        // Directed heads from the plan, then randomized traffic.
        issue(mk(32'h0, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        issue(mk(32'h8, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        issue(mk(32'h100, 5'd1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200));
        issue(mk(32'h300, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400));
        issue(mk(32'h500, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h600));
        issue(mk(32'h700, 5'd0, 32'h704, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h900));
        for (int n = 0; n < N_RANDOM && !abort; n++) begin
            issue(rand_instr());
        end
        tick();
        tick();
        tick();
        mon_en = 1'b0;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        if (!abort) begin
            // Reset while a store waits for its ack; a late ack must do nothing.
            set_head(mk(32'hA0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0), 5'd9);
            head_valid = 1'b1;
            head_done  = 1'b1;
            store_ack  = 1'b0;
            @(negedge clk);
            chk("sw_req_rise", {63'd0, store_commit_req_o}, 64'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("sw_req_hold", {63'd0, store_commit_req_o}, 64'd1);
            chk("sw_no_deq", {63'd0, dequeue_o}, 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_sw_req", {63'd0, store_commit_req_o}, 64'd0);
            chk("rst_sw_deq", {63'd0, dequeue_o}, 64'd0);
            @(posedge clk); #1;
            rst = 1'b1;
            head_valid = 1'b0;
            store_ack  = 1'b1;
            @(negedge clk);
            chk("late_ack_deq", {63'd0, dequeue_o}, 64'd0);
            chk("late_ack_req", {63'd0, store_commit_req_o}, 64'd0);
            chk("post_rst_count", commit_count_o, 64'd0);
            @(posedge clk); #1;
            store_ack = 1'b0;
            @(negedge clk);
            chk("late_ack_deq2", {63'd0, dequeue_o}, 64'd0);
            @(posedge clk); #1;

            // Ack in the very cycle the request first rises.
            head_valid = 1'b1;
            head_done  = 1'b1;
            store_ack  = 1'b1;
            @(negedge clk);
            chk("same_ack_req", {63'd0, store_commit_req_o}, 64'd1);
            chk("same_ack_nodeq", {63'd0, dequeue_o}, 64'd0);
            @(posedge clk); #1;
            store_ack = 1'b0;
            @(negedge clk);
            chk("same_ack_deq", {63'd0, dequeue_o}, 64'd1);
            chk("same_ack_req_drop", {63'd0, store_commit_req_o}, 64'd0);
            @(posedge clk); #1;
            head_valid = 1'b0;
            @(negedge clk);
            chk("same_ack_count", commit_count_o, 64'd1);
            chk("same_ack_idle", {63'd0, dequeue_o}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        fails++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
